alu_rr_arbiter: RTL and testbench

Shares one combinational ALU (ports A, B, Op[3:0] -> O, OF_UND, ERR, ZERO) between N requesters.
- Round-robin arbitration.
- Registers the granted operands and drives the ALU from those registers.
- Captures the ALU result and flags, then returns them through a valid/ready response channel tagged with the requester index.
- The ALU is instantiated beside this block; the bench wires the two together.

---
 rtl/alu_rr_arbiter.sv | 163 ++++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one combinational ALU between N requesters.
// Requesters are picked round-robin. The granted operands are registered and
// drive the ALU. The ALU result and flags are captured one cycle later. They
// are returned on a valid/ready response channel tagged with the requester index.
// Optional build macro: ALU_ARB_STATS_EN adds saturating response/error counters.
//
// Handshake rules (both channels): a transfer happens on a rising edge where
// valid && ready are both high. req_ready is combinational and one-hot, and is
// only raised in IDLE for a requester that is currently valid. rsp_* holds stable
// while rsp_valid=1 and rsp_ready=0. rsp_ready is ignored while rsp_valid=0.
module alu_rr_arbiter #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_valid_i,
  input  logic [N*W-1:0]         req_a_i,
  input  logic [N*W-1:0]         req_b_i,
  input  logic [N*4-1:0]         req_op_i,
  output logic [N-1:0]           req_ready_o,
  output logic [W-1:0]           alu_a_o,
  output logic [W-1:0]           alu_b_o,
  output logic [3:0]             alu_op_o,
  input  logic [W-1:0]           alu_o_i,
  input  logic                   alu_of_und_i,
  input  logic                   alu_err_i,
  input  logic                   alu_zero_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [$clog2(N)-1:0]   rsp_id_o,
  output logic [W-1:0]           rsp_o_o,
  output logic [2:0]             rsp_flags_o,
  output logic [1:0]             dbg_state_o
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]            stat_ops_o,
  output logic [15:0]            stat_errs_o
`endif
);

  localparam int IDW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q;
  logic [W-1:0]     a_q, b_q;
  logic [3:0]       op_q;
  logic [IDW-1:0]   id_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [W-1:0]     rsp_o_q;
  logic [2:0]       rsp_flags_q;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic             accept;
  logic             rsp_hs;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!grant_found && req_valid_i[(int'(rr_ptr_q) + i) % N]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'((int'(rr_ptr_q) + i) % N);
      end
    end
  end

  assign accept = (state_q == IDLE) && grant_found;
  assign rsp_hs = rsp_valid_q && rsp_ready_i;

  // One-hot accept strobe, only while idle and out of reset.
  always_comb begin
    req_ready_o = '0;
    if (accept && !rst) req_ready_o[grant_idx] = 1'b1;
  end

  // Next-state logic: IDLE -> EXEC on a grant, EXEC -> RESP always, RESP -> IDLE on handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_found) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand latch on grant, result capture in EXEC, response release in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_o_q     <= '0;
      rsp_flags_q <= '0;
    end else begin
      if (accept) begin
        a_q      <= req_a_i[int'(grant_idx)*W +: W];
        b_q      <= req_b_i[int'(grant_idx)*W +: W];
        op_q     <= req_op_i[int'(grant_idx)*4 +: 4];
        id_q     <= grant_idx;
        rr_ptr_q <= IDW'((int'(grant_idx) + 1) % N);
      end
      if (state_q == EXEC) begin
        rsp_o_q     <= alu_o_i;
        rsp_flags_q <= {alu_of_und_i, alu_err_i, alu_zero_i};
        rsp_id_q    <= id_q;
        rsp_valid_q <= 1'b1;
      end
      if (state_q == RESP && rsp_ready_i) rsp_valid_q <= 1'b0;
    end
  end

  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
  assign alu_op_o    = op_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_o_o     = rsp_o_q;
  assign rsp_flags_o = rsp_flags_q;
  assign dbg_state_o = state_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat_ops_q, stat_errs_q;

  // Saturating counters of completed responses and of those carrying ERR.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops_q  <= '0;
      stat_errs_q <= '0;
    end else if (rsp_hs) begin
      if (stat_ops_q != 16'hFFFF) stat_ops_q <= stat_ops_q + 16'd1;
      if (rsp_flags_q[1] && stat_errs_q != 16'hFFFF) stat_errs_q <= stat_errs_q + 16'd1;
    end
  end

  assign stat_ops_o  = stat_ops_q;
  assign stat_errs_o = stat_errs_q;
`else
  logic unused_hs;
  assign unused_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a small behavioural ALU wired beside it.
// ALU model: op0 add (OF_UND=carry), op1 sub (OF_UND=borrow), op2 and, op3 or,
// op4 xor, any other opcode sets ERR with O=0; ZERO = !ERR && O==0.
module tb_alu_rr_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N*4-1:0]   req_op;
  logic [N-1:0]     req_ready;
  logic [W-1:0]     alu_a, alu_b, alu_o;
  logic [3:0]       alu_op;
  logic             alu_of_und, alu_err, alu_zero;
  logic             rsp_valid, rsp_ready;
  logic [1:0]       rsp_id;
  logic [W-1:0]     rsp_o;
  logic [2:0]       rsp_flags;
  logic [1:0]       dbg_state;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]      stat_ops, stat_errs;
`endif

  int n_checks;
  int n_pass;
  logic [15:0] exp_q[$];

  alu_rr_arbiter #(.W(W), .N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_op_i     (req_op),
    .req_ready_o  (req_ready),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_op_o     (alu_op),
    .alu_o_i      (alu_o),
    .alu_of_und_i (alu_of_und),
    .alu_err_i    (alu_err),
    .alu_zero_i   (alu_zero),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_o_o      (rsp_o),
    .rsp_flags_o  (rsp_flags),
    .dbg_state_o  (dbg_state)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_ops_o   (stat_ops),
    .stat_errs_o  (stat_errs)
`endif
  );

  // Behavioural ALU.
  logic [W:0] alu_tmp;
  always_comb begin
    alu_tmp    = '0;
    alu_o      = '0;
    alu_of_und = 1'b0;
    alu_err    = 1'b0;
    case (alu_op)
      4'd0: begin alu_tmp = {1'b0, alu_a} + {1'b0, alu_b}; alu_o = alu_tmp[W-1:0]; alu_of_und = alu_tmp[W]; end
      4'd1: begin alu_tmp = {1'b0, alu_a} - {1'b0, alu_b}; alu_o = alu_tmp[W-1:0]; alu_of_und = alu_tmp[W]; end
      4'd2: alu_o = alu_a & alu_b;
      4'd3: alu_o = alu_a | alu_b;
      4'd4: alu_o = alu_a ^ alu_b;
      default: alu_err = 1'b1;
    endcase
    alu_zero = !alu_err && (alu_o == '0);
  end

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_op[id*4 +: 4] = op;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  // One isolated transaction with rsp_ready held high, checked cycle by cycle.
  task automatic do_single(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] op, input logic [7:0] exp_o, input logic [2:0] exp_f);
    set_req(id, a, b, op);
    req_valid = 4'b0001 << id;
    #1;
    check("single_req_ready", 32'(req_ready), 32'(4'b0001 << id));
    tick();
    req_valid = '0;
    check("single_exec_state", 32'(dbg_state), 32'd1);
    check("single_alu_a", 32'(alu_a), 32'(a));
    check("single_alu_b", 32'(alu_b), 32'(b));
    check("single_alu_op", 32'(alu_op), 32'(op));
    check("single_no_early_rsp", 32'(rsp_valid), 32'd0);
    tick();
    check("single_rsp_valid", 32'(rsp_valid), 32'd1);
    check("single_rsp_id", 32'(rsp_id), 32'(id));
    check("single_rsp_o", 32'(rsp_o), 32'(exp_o));
    check("single_rsp_flags", 32'(rsp_flags), 32'(exp_f));
    tick();
    check("single_rsp_done", 32'(rsp_valid), 32'd0);
    check("single_idle", 32'(dbg_state), 32'd0);
  endtask

  // Wait (bounded) for a response and compare {id, o} against the queue head.
  task automatic expect_rsp();
    int waited;
    logic [15:0] exp;
    waited = 0;
    while (!rsp_valid && waited < 10) begin
      tick();
      waited++;
    end
    exp = exp_q.pop_front();
    if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    else check("rr_id_o", {22'd0, rsp_id, rsp_o}, 32'(exp));
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;

    // Reset state, with a requester already valid during reset.
    set_req(0, 8'd5, 8'd10, 4'd0);
    req_valid = 4'b0001;
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_o", 32'(rsp_o), 32'd0);
    check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;

    // Single-requester transactions.
    do_single(0, 8'd5,   8'd10,  4'd0,  8'd15,  3'b000);
    do_single(2, 8'd200, 8'd200, 4'd0,  8'd144, 3'b100);
    do_single(1, 8'd14,  8'd14,  4'd1,  8'd0,   3'b001);
    do_single(3, 8'h3C,  8'h0F,  4'd15, 8'd0,   3'b010);
    do_single(2, 8'd3,   8'd5,   4'd1,  8'hFE,  3'b100);
    do_single(0, 8'hF0,  8'h3C,  4'd4,  8'hCC,  3'b000);

    // All four valid continuously: grants 0,1,2,3,0,1 (a=10*(i+1), b=i+1, add).
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 8'(10 * (i + 1)), 8'(i + 1), 4'd0);
    exp_q = '{16'h000B, 16'h0116, 16'h0221, 16'h032C, 16'h000B, 16'h0116};
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      expect_rsp();
      if (k == 5) req_valid = '0;
      tick();
    end

    // Backpressure: requester 3 granted (rr_ptr=2), requester 0 waits behind it.
    rsp_ready = 1'b0;
    set_req(3, 8'd7, 8'd3, 4'd1);
    set_req(0, 8'd1, 8'd1, 4'd2);
    req_valid = 4'b1001;
    #1;
    check("bp_grant", 32'(req_ready), 32'b1000);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id", 32'(rsp_id), 32'd3);
      check("bp_o", 32'(rsp_o), 32'd4);
      check("bp_flags", 32'(rsp_flags), 32'd0);
      check("bp_no_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_released", 32'(rsp_valid), 32'd0);
    check("bp_next_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    tick();
    check("bp2_valid", 32'(rsp_valid), 32'd1);
    check("bp2_id_o", {22'd0, rsp_id, rsp_o}, 32'h0001);
    tick();
    check("bp2_done", 32'(rsp_valid), 32'd0);

    // Reset while in EXEC drops the operation and clears rr_ptr.
    set_req(1, 8'd14, 8'd2, 4'd1);
    req_valid = 4'b0010;
    tick();
    check("mid_exec_state", 32'(dbg_state), 32'd1);
    rst = 1'b1;
    set_req(1, 8'd9, 8'd4, 4'd0);
    req_valid = 4'b1010;
    tick();
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    check("mid_rst_alu_a", 32'(alu_a), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rr_restart", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    check("mid_new_alu_a", 32'(alu_a), 32'd9);
    tick();
    check("mid_rsp_valid", 32'(rsp_valid), 32'd1);
    check("mid_rsp_id_o", {22'd0, rsp_id, rsp_o}, 32'h010D);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("mid_no_ghost", 32'(rsp_valid), 32'd0);
    end

`ifdef ALU_ARB_STATS_EN
    do_reset();
    check("stat_rst_ops", 32'(stat_ops), 32'd0);
    do_single(0, 8'd1, 8'd2, 4'd0,  8'd3, 3'b000);
    do_single(1, 8'd6, 8'd3, 4'd2,  8'd2, 3'b000);
    do_single(2, 8'd6, 8'd3, 4'd3,  8'd7, 3'b000);
    do_single(3, 8'd6, 8'd3, 4'd15, 8'd0, 3'b010);
    check("stat_ops", 32'(stat_ops), 32'd4);
    check("stat_errs", 32'(stat_errs), 32'd1);
    do_reset();
    check("stat_ops_rst", 32'(stat_ops), 32'd0);
    check("stat_errs_rst", 32'(stat_errs), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
